// File: rtl/hk_mash_cfg_pkg.sv
// Shared constants for the configurable HK-EFM MASH: LFSR definition,
// order range handling and output width.
package hk_mash_pkg;

    localparam int unsigned      LFSR_W            = 15;
    localparam logic [14:0]      LFSR_SEED_DEFAULT = 15'h4A5F;
    // x^15 + x^14 + 1, Fibonacci form shifting towards the MSB
    localparam int unsigned      LFSR_TAP_A        = 14;
    localparam int unsigned      LFSR_TAP_B        = 13;

    localparam int unsigned      ORD_MIN           = 1;
    localparam int unsigned      ORD_W             = 3;

    function automatic logic [ORD_W-1:0] clamp_order(input logic [ORD_W-1:0] ord,
                                                      input int unsigned      max_ord);
        logic [ORD_W-1:0] r;
        if (ord == '0) begin
            r = ORD_W'(ORD_MIN);
        end else if (32'(ord) > max_ord) begin
            r = ORD_W'(max_ord);
        end else begin
            r = ord;
        end
        return r;
    endfunction

    function automatic int unsigned y_width(input int unsigned max_order);
        return max_order + 1;
    endfunction

endpackage

// File: rtl/hk_mash_cfg_stage.sv
// One HK-EFM first-order accumulator stage with carry history.
// A disabled or cleared stage is forced to all-zero state.
module hk_efm_stage
    import hk_mash_pkg::*;
#(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned A_GAIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             c_o,
    output logic             c_d_o,
    output logic             c_dd_o
);

    typedef logic [WIDTH:0] sum_t;
    localparam sum_t GAIN = sum_t'(A_GAIN);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             cd1_q, cd1_d;
    logic             cd2_q, cd2_d;
    sum_t             sum;

    always_comb begin
        sum = {1'b0, in_i} + {1'b0, acc_q} + (carry_q ? GAIN : '0);
        if (clr_i || !en_i) begin
            acc_d   = '0;
            carry_d = 1'b0;
            cd1_d   = 1'b0;
            cd2_d   = 1'b0;
        end else begin
            acc_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            cd1_d   = carry_q;
            cd2_d   = cd1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            cd1_q   <= 1'b0;
            cd2_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cd1_q   <= cd1_d;
            cd2_q   <= cd2_d;
        end
    end

    assign acc_o  = acc_q;
    assign c_o    = carry_q;
    assign c_d_o  = cd1_q;
    assign c_dd_o = cd2_q;

endmodule

// File: rtl/hk_mash_cfg.sv
// Run-time order-selectable HK-EFM MASH DDSM with handshaked reload of
// input word and order, optional LSB dither and optional output register.
module hk_mash_cfg
    import hk_mash_pkg::*;
#(
    parameter int unsigned       WIDTH     = 9,
    parameter int unsigned       MAX_ORDER = 3,
    parameter int unsigned       A_GAIN    = 2,
    parameter int unsigned       OUT_REG   = 1,
    parameter int unsigned       DITHER    = 0,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       x_i,
    input  logic [2:0]             ord_i,
    input  logic                   ld_i,
    output logic                   ld_ack_o,
    input  logic                   clr_i,
    output logic signed [MAX_ORDER:0] y_o,
    output logic [WIDTH-1:0]       e_o
);

    localparam int unsigned YW = y_width(MAX_ORDER);

    logic [WIDTH-1:0]     x_q, x_d;
    logic [2:0]           ord_q, ord_d;
    logic                 ack_q, ack_d;
    logic                 apply;
    logic [2:0]           ord_req, en_ord;
    logic                 dither;

    logic [WIDTH-1:0]     acc [MAX_ORDER];
    logic [MAX_ORDER-1:0] c_vec, cd1_vec, cd2_vec, stage_en;
    logic [3:0]           c_all, cd1_all, cd2_all;
    logic                 c4_ddd;

    logic signed [7:0]    y_run;
    logic signed [YW-1:0] y_sel;
    logic [WIDTH-1:0]     e_sel;

    // Shrinking the order disables stages on the apply edge itself; growing it
    // keeps the new stages in reset for that edge so they start from zero.
    always_comb begin
        apply   = ld_i && !clr_i;
        ord_req = clamp_order(ord_i, MAX_ORDER);
        en_ord  = ord_q;
        if (apply && (ord_req < ord_q)) en_ord = ord_req;
        x_d     = apply ? x_i : x_q;
        ord_d   = apply ? ord_req : ord_q;
        ack_d   = apply;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            ord_q <= 3'(MAX_ORDER);
            ack_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            ord_q <= ord_d;
            ack_q <= ack_d;
        end
    end

    assign ld_ack_o = ack_q;

    if (DITHER != 0) begin : g_lfsr
        logic [LFSR_W-1:0] lfsr_q, lfsr_d;
        always_comb begin
            lfsr_d = clr_i ? LFSR_SEED
                           : {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) lfsr_q <= LFSR_SEED;
            else        lfsr_q <= lfsr_d;
        end
        assign dither = lfsr_q[0];
    end else begin : g_no_lfsr
        assign dither = 1'b0;
    end

    for (genvar k = 0; k < MAX_ORDER; k++) begin : g_stage
        logic [WIDTH-1:0] in_k;
        if (k == 0) begin : g_first
            assign in_k = x_q + {{(WIDTH-1){1'b0}}, dither};
        end else begin : g_chain
            assign in_k = acc[k-1];
        end
        assign stage_en[k] = (32'(en_ord) > k);
        hk_efm_stage #(
            .WIDTH  (WIDTH),
            .A_GAIN (A_GAIN)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (stage_en[k]),
            .clr_i  (clr_i),
            .in_i   (in_k),
            .acc_o  (acc[k]),
            .c_o    (c_vec[k]),
            .c_d_o  (cd1_vec[k]),
            .c_dd_o (cd2_vec[k])
        );
    end

    if (MAX_ORDER == 4) begin : g_c4_d3
        logic c4_d3_q, c4_d3_d;
        always_comb c4_d3_d = (clr_i || !stage_en[3]) ? 1'b0 : cd2_vec[3];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) c4_d3_q <= 1'b0;
            else        c4_d3_q <= c4_d3_d;
        end
        assign c4_ddd = c4_d3_q;
    end else begin : g_no_c4_d3
        assign c4_ddd = 1'b0;
    end

    function automatic logic signed [7:0] b2s(input logic b);
        return {7'b0, b};
    endfunction

    always_comb begin
        c_all   = '0;
        cd1_all = '0;
        cd2_all = '0;
        c_all[MAX_ORDER-1:0]   = c_vec;
        cd1_all[MAX_ORDER-1:0] = cd1_vec;
        cd2_all[MAX_ORDER-1:0] = cd2_vec;
        y_run = '0;
        y_sel = '0;
        e_sel = '0;
        for (int unsigned k = 0; k < MAX_ORDER; k++) begin
            case (k)
                0: y_run = y_run + b2s(c_all[0]);
                1: y_run = y_run + b2s(c_all[1]) - b2s(cd1_all[1]);
                2: y_run = y_run + b2s(c_all[2]) - 8'sd2 * b2s(cd1_all[2]) + b2s(cd2_all[2]);
                default: y_run = y_run + b2s(c_all[3]) - 8'sd3 * b2s(cd1_all[3])
                                 + 8'sd3 * b2s(cd2_all[3]) - b2s(c4ddd_w());
            endcase
            if (k + 1 == 32'(ord_q)) begin
                y_sel = y_run[YW-1:0];
                e_sel = acc[k];
            end
        end
    end

    function automatic logic c4ddd_w();
        return c4_ddd;
    endfunction

    if (OUT_REG != 0) begin : g_out_reg
        logic signed [YW-1:0] y_q, y_d;
        logic [WIDTH-1:0]     e_q, e_d;
        always_comb begin
            y_d = clr_i ? '0 : y_sel;
            e_d = clr_i ? '0 : e_sel;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_q <= '0;
                e_q <= '0;
            end else begin
                y_q <= y_d;
                e_q <= e_d;
            end
        end
        assign y_o = y_q;
        assign e_o = e_q;
    end else begin : g_out_comb
        assign y_o = y_sel;
        assign e_o = e_sel;
    end

endmodule

// File: tb/tb_hk_mash_cfg.sv
// Bench for hk_mash_cfg: clamp table, mean/range runs, order switching,
// clear/reset corners and a dithered instance against a reference model.
module tb_hk_mash_cfg;

    localparam int unsigned W  = 9;
    localparam int unsigned WD = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [W-1:0]       x_i = '0;
    logic [2:0]         ord_i = 3'd1;
    logic               ld_i = 1'b0, clr_i = 1'b0;
    logic               ld_ack_o;
    logic signed [3:0]  y_o;
    logic [W-1:0]       e_o;

    logic [WD-1:0]      dx_i = '0;
    logic [2:0]         dord_i = 3'd1;
    logic               dld_i = 1'b0, dclr_i = 1'b0;
    logic               dld_ack_o;
    logic signed [3:0]  dy_o;
    logic [WD-1:0]      de_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hk_mash_cfg #(.WIDTH(W), .MAX_ORDER(3), .A_GAIN(2), .OUT_REG(1), .DITHER(0),
                  .LFSR_SEED(15'h4A5F)) dut (
        .clk(clk), .rst_n(rst_n), .x_i(x_i), .ord_i(ord_i), .ld_i(ld_i),
        .ld_ack_o(ld_ack_o), .clr_i(clr_i), .y_o(y_o), .e_o(e_o));

    hk_mash_cfg #(.WIDTH(WD), .MAX_ORDER(3), .A_GAIN(2), .OUT_REG(1), .DITHER(1),
                  .LFSR_SEED(15'h4A5F)) dut_d (
        .clk(clk), .rst_n(rst_n), .x_i(dx_i), .ord_i(dord_i), .ld_i(dld_i),
        .ld_ack_o(dld_ack_o), .clr_i(dclr_i), .y_o(dy_o), .e_o(de_o));

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_ld(input logic [W-1:0] x, input logic [2:0] ord);
        bit seen = 0;
        ld_i  = 1'b1;
        x_i   = x;
        ord_i = ord;
        for (int unsigned i = 0; i < 4 && !seen; i++) begin
            tick();
            if (ld_ack_o) seen = 1;
        end
        check("ld_ack_seen", seen, 1);
        ld_i = 1'b0;
    endtask

    typedef struct packed {
        logic [2:0]   ord;
        logic [W-1:0] x;
        logic [2:0]   exp_ord;
    } vec_t;

    typedef struct packed {
        logic          c;
        logic [WD-1:0] acc;
    } exp_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          vt [6];
        exp_t          q [$];
        exp_t          ex;
        int            sum, viol, acks;
        logic [14:0]   m_l;
        logic [WD-1:0] m_acc;
        logic          m_c;
        logic [WD:0]   s;
        bit            nz;

        vt[0] = '{3'd0, 9'd5,   3'd1};
        vt[1] = '{3'd1, 9'd7,   3'd1};
        vt[2] = '{3'd2, 9'd100, 3'd2};
        vt[3] = '{3'd3, 9'd511, 3'd3};
        vt[4] = '{3'd4, 9'd3,   3'd3};
        vt[5] = '{3'd7, 9'd0,   3'd3};

        // reset state
        do_reset();
        check("rst_y", y_o, 0);
        check("rst_e", e_o, 0);
        check("rst_ack", ld_ack_o, 0);
        check("rst_x_shadow", dut.x_q, 0);
        check("rst_ord_shadow", dut.ord_q, 3);

        // order clamp and handshake table
        for (int i = 0; i < 6; i++) begin
            ld_i = 1'b1; x_i = vt[i].x; ord_i = vt[i].ord;
            tick();
            check("tbl_ack_hi", ld_ack_o, 1);
            check("tbl_ord", dut.ord_q, vt[i].exp_ord);
            check("tbl_x", dut.x_q, vt[i].x);
            ld_i = 1'b0;
            tick();
            check("tbl_ack_lo", ld_ack_o, 0);
        end

        // order-1 mean
        do_reset();
        apply_ld(9'd16, 3'd1);
        sum = 0; viol = 0;
        repeat (5100) begin
            tick();
            sum += int'(y_o);
            if (y_o != 0 && y_o != 1) viol++;
        end
        check_tol("o1_sum", sum, 159, 161);
        check("o1_binary_viol", viol, 0);

        // order-3 mean and range
        do_reset();
        apply_ld(9'd16, 3'd3);
        sum = 0; viol = 0;
        repeat (10200) begin
            tick();
            sum += int'(y_o);
            if (y_o < -3 || y_o > 4) viol++;
        end
        check_tol("o3_sum", sum, 317, 323);
        check("o3_range_viol", viol, 0);

        // live order switch 3 -> 1 -> 3
        do_reset();
        apply_ld(9'd255, 3'd3);
        repeat (100) tick();
        apply_ld(9'd255, 3'd1);
        check("sw_down_acc2", dut.g_stage[1].u_stage.acc_q, 0);
        check("sw_down_acc3", dut.g_stage[2].u_stage.acc_q, 0);
        check("sw_down_ord", dut.ord_q, 1);
        acks = 0; viol = 0;
        repeat (100) begin
            tick();
            if (ld_ack_o) acks++;
            if (y_o != 0 && y_o != 1) viol++;
        end
        check("sw_down_extra_acks", acks, 0);
        check("sw_down_binary_viol", viol, 0);
        apply_ld(9'd255, 3'd3);
        check("sw_up_new_acc2", dut.g_stage[1].u_stage.acc_q, 0);
        check_tol("sw_up_transition_y", y_o, 0, 1);
        viol = 0;
        repeat (200) begin
            tick();
            if (y_o < -3 || y_o > 4) viol++;
        end
        check("sw_up_range_viol", viol, 0);

        // clr_i together with ld_i
        clr_i = 1'b1; ld_i = 1'b1; x_i = 9'd100; ord_i = 3'd2;
        tick();
        check("clr_ack", ld_ack_o, 0);
        check("clr_acc1", dut.g_stage[0].u_stage.acc_q, 0);
        check("clr_acc2", dut.g_stage[1].u_stage.acc_q, 0);
        check("clr_acc3", dut.g_stage[2].u_stage.acc_q, 0);
        check("clr_x_kept", dut.x_q, 255);
        check("clr_ord_kept", dut.ord_q, 3);
        check("clr_y", y_o, 0);
        check("clr_e", e_o, 0);
        clr_i = 1'b0; ld_i = 1'b0;
        tick();
        check("clr_y_next", y_o, 0);
        check("clr_e_next", e_o, 0);

        // held ld_i then asynchronous reset mid-run
        ld_i = 1'b1; x_i = 9'd255; ord_i = 3'd3;
        viol = 0;
        repeat (40) begin
            tick();
            if (!ld_ack_o) viol++;
        end
        check("hold_ack_every_cycle", viol, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_y", y_o, 0);
        check("arst_e", e_o, 0);
        check("arst_ack", ld_ack_o, 0);
        check("arst_x", dut.x_q, 0);
        check("arst_ord", dut.ord_q, 3);
        ld_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        repeat (50) begin
            tick();
            if (y_o != 0 || e_o != 0) viol++;
        end
        check("arst_idle_nonzero", viol, 0);

        // dithered instance against a reference LFSR/accumulator model
        dld_i = 1'b1; dx_i = '0; dord_i = 3'd1;
        tick();
        check("d_ack", dld_ack_o, 1);
        dld_i = 1'b0; dclr_i = 1'b1;
        tick();
        check("d_clr_y", dy_o, 0);
        check("d_lfsr_seed", dut_d.g_lfsr.lfsr_q, 15'h4A5F);
        dclr_i = 1'b0;
        m_l = 15'h4A5F; m_acc = '0; m_c = 1'b0; nz = 0;
        q.push_back('{1'b0, {WD{1'b0}}});
        repeat (600) begin
            s = {1'b0, m_acc} + {{WD{1'b0}}, m_l[0]} + (m_c ? 7'd2 : 7'd0);
            m_c   = s[WD];
            m_acc = s[WD-1:0];
            m_l   = {m_l[13:0], m_l[14] ^ m_l[13]};
            q.push_back('{m_c, m_acc});
            tick();
            ex = q.pop_front();
            check("d_y", dy_o, ex.c);
            check("d_e", de_o, ex.acc);
            check("d_lfsr", dut_d.g_lfsr.lfsr_q, m_l);
            if (dy_o != 0) nz = 1;
        end
        check("d_y_nonzero_seen", nz, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
